// File: rtl/sha2_pkg.sv
// Shared types and constants for the SHA-2 message padder: mode and state
// encodings, the maximum word type and the Pad80 byte-lane helper.
package sha2_pkg;

   localparam int MaxDataW   = 64;
   localparam int BlockWords = 16;
   localparam int LenHiIdx   = 14;

   typedef logic [MaxDataW-1:0] sha_word_t;

   typedef enum logic {
      Sha256 = 1'b0,
      Sha512 = 1'b1
   } sha2_mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StReceive,
      StPad80,
      StPad00,
      StLenHi,
      StLenLo
   } pad_st_e;

   // pos counts byte lanes from the most significant byte of the active word
   function automatic logic [7:0] pad_byte(input logic [7:0] din,
                                           input logic [2:0] pos,
                                           input logic [2:0] b);
      if (pos < b) begin
         return din;
      end else if (pos == b) begin
         return 8'h80;
      end else begin
         return 8'h00;
      end
   endfunction

endpackage

// File: rtl/sha2_pad80_gen.sv
// Builds the word carrying the 0x80 pad marker: the leading pad_bytes bytes of
// the message word are kept, then 0x80, then zeros.
module sha2_pad80_gen
   import sha2_pkg::*;
(
   input  sha_word_t  data,
   input  sha2_mode_e mode,
   input  logic [2:0] pad_bytes,
   output sha_word_t  word
);

   genvar gi;
   generate
      for (gi = 0; gi < MaxDataW / 8; gi++) begin : g_lane
         localparam int Hi = MaxDataW - 1 - 8 * gi;
         if (gi < 4) begin : g_upper
            // Upper half carries nothing in 32-bit word mode
            assign word[Hi -: 8] = (mode == Sha512) ?
                                   pad_byte(data[Hi -: 8], 3'(gi), pad_bytes) : 8'h00;
         end else begin : g_lower
            assign word[Hi -: 8] = pad_byte(data[Hi -: 8],
                                            (mode == Sha512) ? 3'(gi) : 3'(gi - 4),
                                            pad_bytes);
         end
      end
   endgenerate

endmodule

// File: rtl/sha2_pad.sv
// SHA-256/512 message padder: passes FIFO words to the compression engine,
// then appends the 0x80 marker, zero fill and the big-endian length field.
module sha2_pad
   import sha2_pkg::*;
#(
   parameter int DataW    = 64,
   parameter bit EnSha512 = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               sha_en,
   input  logic               mode_i,
   input  logic               hash_start,
   input  logic               hash_process,
   input  logic               hash_done,
   input  logic [127:0]       message_length,
   input  logic               fifo_rvalid,
   input  logic [DataW-1:0]   fifo_rdata,
   input  logic [DataW/8-1:0] fifo_rmask,
   output logic               fifo_rready,
   output logic               shaf_rvalid,
   output logic [DataW-1:0]   shaf_rdata,
   input  logic               shaf_rready,
   output logic               msg_feed_complete
);

   localparam int WidxW = $clog2(BlockWords);
   localparam logic [WidxW-1:0] LastPadIdx = WidxW'(LenHiIdx - 1);

   pad_st_e          state_reg;
   sha2_mode_e       mode_reg;
   logic [WidxW-1:0] widx_reg;
   logic [127:0]     tx_bits_reg;
   logic             hash_process_flag_reg;

   logic             is_512;
   logic             mask_full;
   logic [2:0]       pad_bytes;
   logic [127:0]     word_bits;
   sha_word_t        fifo_ext;
   sha_word_t        fifo_word;
   sha_word_t        pad80_word;
   sha_word_t        out_word;
   logic             valid_next;
   logic             rready_next;
   logic             active;
   logic             accept;

   assign is_512    = (mode_reg == Sha512);
   assign fifo_ext  = sha_word_t'(fifo_rdata);
   assign fifo_word = is_512 ? fifo_ext : {32'h0, fifo_ext[31:0]};
   assign mask_full = is_512 ? (&fifo_rmask) : (&fifo_rmask[3:0]);
   assign pad_bytes = is_512 ? message_length[5:3] : {1'b0, message_length[4:3]};
   assign word_bits = is_512 ? 128'd64 : 128'd32;

   sha2_pad80_gen u_pad80 (
      .data      (fifo_word),
      .mode      (mode_reg),
      .pad_bytes (pad_bytes),
      .word      (pad80_word)
   );

   always_comb begin
      valid_next  = 1'b0;
      rready_next = 1'b0;
      out_word    = '0;
      unique case (state_reg)
         StReceive: begin
            // A partial word is never popped here; Pad80 merges and pops it
            if (!(fifo_rvalid && !mask_full) &&
                (!hash_process_flag_reg || tx_bits_reg != message_length)) begin
               valid_next  = fifo_rvalid;
               rready_next = shaf_rready;
               out_word    = fifo_word;
            end
         end
         StPad80: begin
            valid_next  = 1'b1;
            rready_next = shaf_rready && (pad_bytes != 3'd0);
            out_word    = pad80_word;
         end
         StPad00: begin
            valid_next = 1'b1;
         end
         StLenHi: begin
            valid_next = 1'b1;
            out_word   = is_512 ? message_length[127:64] : {32'h0, message_length[63:32]};
         end
         StLenLo: begin
            valid_next = 1'b1;
            out_word   = is_512 ? message_length[63:0] : {32'h0, message_length[31:0]};
         end
         default: begin
         end
      endcase
   end

   assign active            = rst_ni && sha_en;
   assign shaf_rvalid       = active && valid_next;
   assign fifo_rready       = active && rready_next;
   assign shaf_rdata        = active ? DataW'(out_word) : '0;
   assign msg_feed_complete = rst_ni && hash_process_flag_reg && (state_reg == StIdle);
   assign accept            = shaf_rvalid && shaf_rready;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg             <= StIdle;
         mode_reg              <= Sha256;
         widx_reg              <= '0;
         tx_bits_reg           <= '0;
         hash_process_flag_reg <= 1'b0;
      end else begin
         if (hash_process) begin
            hash_process_flag_reg <= 1'b1;
         end else if (hash_done || hash_start) begin
            hash_process_flag_reg <= 1'b0;
         end

         if (hash_start) begin
            widx_reg    <= '0;
            tx_bits_reg <= '0;
         end else if (accept) begin
            widx_reg <= widx_reg + 1'b1;
            if (state_reg inside {StReceive, StPad80, StPad00}) begin
               tx_bits_reg <= tx_bits_reg + word_bits;
            end
         end

         if (!sha_en) begin
            state_reg <= StIdle;
         end else if (hash_start) begin
            state_reg <= StReceive;
            mode_reg  <= EnSha512 ? sha2_mode_e'(mode_i) : Sha256;
         end else begin
            unique case (state_reg)
               StIdle: state_reg <= StIdle;
               StReceive: begin
                  if (fifo_rvalid && !mask_full) begin
                     state_reg <= StPad80;
                  end else if (hash_process_flag_reg && tx_bits_reg == message_length) begin
                     state_reg <= StPad80;
                  end
               end
               StPad80: begin
                  if (accept) begin
                     state_reg <= (widx_reg == LastPadIdx) ? StLenHi : StPad00;
                  end
               end
               StPad00: begin
                  if (accept && widx_reg == LastPadIdx) begin
                     state_reg <= StLenHi;
                  end
               end
               StLenHi: begin
                  if (accept) begin
                     state_reg <= StLenLo;
                  end
               end
               StLenLo: begin
                  if (accept) begin
                     state_reg <= StIdle;
                  end
               end
               default: state_reg <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha2_pad.sv
// Randomised bench for sha2_pad: a byte-level SHA-2 padding model builds the
// expected word stream, a queue-backed FIFO feeds the message.
module tb_sha2_pad;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         sha_en;
   logic         mode_i;
   logic         hash_start;
   logic         hash_process;
   logic         hash_done;
   logic [127:0] message_length;
   logic         fifo_rvalid;
   logic [63:0]  fifo_rdata;
   logic [7:0]   fifo_rmask;
   logic         fifo_rready;
   logic         shaf_rvalid;
   logic [63:0]  shaf_rdata;
   logic         shaf_rready;
   logic         msg_feed_complete;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] fifo_data_q[$];
   logic [7:0]  fifo_mask_q[$];
   logic [63:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   sha2_pad #(.DataW(64), .EnSha512(1'b1)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .sha_en            (sha_en),
      .mode_i            (mode_i),
      .hash_start        (hash_start),
      .hash_process      (hash_process),
      .hash_done         (hash_done),
      .message_length    (message_length),
      .fifo_rvalid       (fifo_rvalid),
      .fifo_rdata        (fifo_rdata),
      .fifo_rmask        (fifo_rmask),
      .fifo_rready       (fifo_rready),
      .shaf_rvalid       (shaf_rvalid),
      .shaf_rdata        (shaf_rdata),
      .shaf_rready       (shaf_rready),
      .msg_feed_complete (msg_feed_complete)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Standard SHA-2 padding on a byte list, then split into big-endian words
   task automatic load_hash(input bit m, input int len, input bit abc);
      int          wb;
      int          bb;
      int          lb;
      logic [7:0]  msg[$];
      logic [7:0]  pad[$];
      logic [127:0] lbits;
      logic [63:0] data;
      logic [7:0]  mask;
      logic [63:0] w;
      wb = m ? 8 : 4;
      bb = 16 * wb;
      lb = 2 * wb;
      fifo_data_q.delete();
      fifo_mask_q.delete();
      exp_q.delete();
      for (int i = 0; i < len; i++) msg.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
      for (int k = 0; k * wb < len; k++) begin
         data = {$urandom, $urandom};
         mask = 8'($urandom);
         for (int j = 0; j < wb; j++) begin
            int lane;
            lane = wb - 1 - j;
            if (k * wb + j < len) begin
               data[8*lane +: 8] = msg[k*wb + j];
               mask[lane] = 1'b1;
            end else begin
               mask[lane] = 1'b0;
            end
         end
         fifo_data_q.push_back(data);
         fifo_mask_q.push_back(mask);
      end
      pad = msg;
      pad.push_back(8'h80);
      while ((pad.size() % bb) != (bb - lb)) pad.push_back(8'h00);
      lbits = 128'(len) * 128'd8;
      for (int i = lb - 1; i >= 0; i--) pad.push_back(lbits[8*i +: 8]);
      for (int k = 0; k < pad.size() / wb; k++) begin
         w = '0;
         for (int j = 0; j < wb; j++) w = {w[55:0], pad[k*wb + j]};
         exp_q.push_back(w);
      end
   endtask

   task automatic start_hash(input bit m, input int len);
      @(negedge clk_i);
      sha_en         = 1'b1;
      hash_start     = 1'b1;
      mode_i         = m;
      message_length = 128'(len) * 128'd8;
      shaf_rready    = 1'b0;
      fifo_rvalid    = 1'b0;
      @(posedge clk_i);
   endtask

   task automatic run_hash(input bit m, input int len, input bit abc, input int abort_after,
                           input bit stall_len, input int want_words, input string name);
      int          seen;
      int          budget;
      int          stall_cnt;
      int          want;
      bit          first;
      bit          popped;
      bit          prev_stall;
      bit          done;
      logic [63:0] prev_data;
      seen = 0; budget = 0; stall_cnt = 0; first = 1'b1; popped = 1'b0;
      prev_stall = 1'b0; prev_data = '0;
      load_hash(m, len, abc);
      want = (want_words < 0) ? exp_q.size() : want_words;
      start_hash(m, len);
      while (1) begin
         @(negedge clk_i);
         hash_start   = 1'b0;
         hash_process = first;
         first        = 1'b0;
         mode_i       = 1'($urandom);
         if (popped) fifo_rvalid = 1'b0;
         popped = 1'b0;
         if (!fifo_rvalid && fifo_data_q.size() > 0 && $urandom_range(0, 3) != 0) fifo_rvalid = 1'b1;
         if (fifo_rvalid) begin
            fifo_rdata = fifo_data_q[0];
            fifo_rmask = fifo_mask_q[0];
         end else begin
            fifo_rdata = {$urandom, $urandom};
            fifo_rmask = 8'($urandom);
         end
         shaf_rready = ($urandom_range(0, 3) != 0);
         if (stall_len && exp_q.size() == 1 && stall_cnt < 5) begin
            shaf_rready = 1'b0;
            stall_cnt++;
         end
         #1;
         if (prev_stall) begin
            check({name, "_hold_valid"}, 128'(shaf_rvalid), 128'd1);
            check({name, "_hold_data"}, 128'(shaf_rdata), 128'(prev_data));
         end
         prev_stall = shaf_rvalid && !shaf_rready;
         prev_data  = shaf_rdata;
         if (shaf_rvalid && shaf_rready) begin
            if (exp_q.size() == 0) begin
               check({name, "_extra_word"}, 128'd1, 128'd0);
            end else begin
               check($sformatf("%s_word%0d", name, seen), 128'(shaf_rdata), 128'(exp_q.pop_front()));
            end
            seen++;
         end
         if (fifo_rvalid && fifo_rready) begin
            void'(fifo_data_q.pop_front());
            void'(fifo_mask_q.pop_front());
            popped = 1'b1;
         end
         done = (exp_q.size() == 0) || (abort_after > 0 && seen >= abort_after);
         @(posedge clk_i);
         if (done) break;
         budget++;
         if (budget >= 4000) begin
            check({name, "_timeout"}, 128'(budget), 128'd0);
            break;
         end
      end
      if (abort_after == 0) begin
         @(negedge clk_i);
         hash_process = 1'b0;
         fifo_rvalid  = 1'b0;
         shaf_rready  = 1'b0;
         #1;
         check({name, "_complete"}, 128'(msg_feed_complete), 128'd1);
         check({name, "_idle_valid"}, 128'(shaf_rvalid), 128'd0);
         check({name, "_nwords"}, 128'(seen), 128'(want));
         check({name, "_fifo_drained"}, 128'(fifo_data_q.size()), 128'd0);
      end
      hash_process = 1'b0;
      fifo_rvalid  = 1'b0;
      $display("[TB] hash %s mode=%0d len_bytes=%0d words=%0d", name, m, len, seen);
   endtask

   initial begin
      rst_ni = 1'b0; sha_en = 1'b1; mode_i = 1'b1; hash_start = 1'b1;
      hash_process = 1'b1; hash_done = 1'b0; message_length = 128'd24;
      fifo_rvalid = 1'b1; fifo_rdata = 64'hFFFF_FFFF_FFFF_FFFF; fifo_rmask = 8'hFF;
      shaf_rready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i); #1;
         check("rst_rvalid", 128'(shaf_rvalid), 128'd0);
         check("rst_rready", 128'(fifo_rready), 128'd0);
         check("rst_complete", 128'(msg_feed_complete), 128'd0);
         check("rst_rdata", 128'(shaf_rdata), 128'd0);
      end
      @(negedge clk_i);
      rst_ni = 1'b1; hash_start = 1'b0; hash_process = 1'b0;
      #1;
      check("post_rst_rvalid", 128'(shaf_rvalid), 128'd0);
      check("post_rst_complete", 128'(msg_feed_complete), 128'd0);

      run_hash(1'b0, 3, 1'b1, 0, 1'b1, 16, "abc256");
      // flag clears on hash_done, but hash_process wins when coincident
      @(negedge clk_i); hash_done = 1'b1;
      @(negedge clk_i); hash_done = 1'b0; #1;
      check("done_clears_flag", 128'(msg_feed_complete), 128'd0);
      @(negedge clk_i); hash_done = 1'b1; hash_process = 1'b1;
      @(negedge clk_i); hash_done = 1'b0; hash_process = 1'b0; #1;
      check("process_wins", 128'(msg_feed_complete), 128'd1);

      run_hash(1'b1, 3, 1'b1, 0, 1'b0, 16, "abc512");
      run_hash(1'b0, 56, 1'b0, 0, 1'b0, 32, "len448");
      run_hash(1'b1, 104, 1'b0, 0, 1'b1, 16, "len832");

      // restart from Pad00: the new hash must start from clean counters
      run_hash(1'b0, 3, 1'b1, 2, 1'b0, 0, "abort_pad00");
      run_hash(1'b1, 20, 1'b0, 0, 1'b0, -1, "after_restart");

      // sha_en dropped while in Pad80
      load_hash(1'b0, 3, 1'b1);
      start_hash(1'b0, 3);
      @(negedge clk_i);
      hash_start = 1'b0; fifo_rvalid = 1'b1;
      fifo_rdata = fifo_data_q[0]; fifo_rmask = fifo_mask_q[0];
      @(negedge clk_i); #1;
      check("pad80_valid", 128'(shaf_rvalid), 128'd1);
      check("pad80_data", 128'(shaf_rdata), 128'(exp_q[0]));
      @(negedge clk_i);
      sha_en = 1'b0; shaf_rready = 1'b1; #1;
      check("en_low_rvalid", 128'(shaf_rvalid), 128'd0);
      check("en_low_rready", 128'(fifo_rready), 128'd0);
      @(negedge clk_i);
      sha_en = 1'b1; #1;
      check("en_idle_rvalid", 128'(shaf_rvalid), 128'd0);
      check("en_idle_rready", 128'(fifo_rready), 128'd0);
      fifo_rvalid = 1'b0;

      for (int t = 0; t < 10; t++) begin
         run_hash(1'($urandom), $urandom_range(0, 200), 1'b0, 0, 1'($urandom), -1,
                  $sformatf("rand%0d", t));
      end

      // reset in the middle of a hash abandons it
      run_hash(1'b1, 100, 1'b0, 5, 1'b0, 0, "mid_reset");
      @(negedge clk_i);
      rst_ni = 1'b0; fifo_rvalid = 1'b1; fifo_rmask = 8'hFF; shaf_rready = 1'b1; #1;
      check("midrst_rvalid", 128'(shaf_rvalid), 128'd0);
      check("midrst_rdata", 128'(shaf_rdata), 128'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i); #1;
         check("after_rst_rvalid", 128'(shaf_rvalid), 128'd0);
         check("after_rst_rready", 128'(fifo_rready), 128'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sha2_pad.md
SHA2_PAD -- requirements
Module: sha2_pad

Interface
REQ-001 Parameter DataW, default 64, SHALL set the maximum word width; legal values are 32 or 64.
REQ-002 Parameter EnSha512, default 1, SHALL select mode support; 0 ties the mode to SHA-256 and requires DataW=32.
REQ-003 clk_i  in  1  sole clock; reset is synchronous and active-low.
REQ-004 rst_ni  in  1  synchronous active-low reset.
REQ-005 sha_en  in  1  engine enable.
REQ-006 mode_i  in  1  0=SHA-256 (32b words, 64b length field), 1=SHA-512 (64b words, 128b length field).
REQ-007 hash_start, hash_process, hash_done  in  1 each  single-cycle command pulses.
REQ-008 message_length  in  128  message length in bits, 8-bit granularity.
REQ-009 fifo_rvalid  in  1; fifo_rdata  in  DataW; fifo_rmask  in  DataW/8; fifo_rready  out  1  message FIFO read port, MSB-first byte lanes.
REQ-010 shaf_rvalid  out  1; shaf_rdata  out  DataW; shaf_rready  in  1  word stream to the compression engine.
REQ-011 msg_feed_complete  out  1  all padded words have been delivered.

Function
REQ-012 mode_i SHALL be latched as mode_q on sha_en && hash_start, and mode_i SHALL be ignored at all other times; W=32 for SHA-256 and W=64 for SHA-512; in SHA-256 mode only the bits [31:0] and the mask bits [3:0] are active, and shaf_rdata[DataW-1:32] SHALL be 0.
REQ-013 A 4-bit word index widx SHALL count accepted output words (shaf_rvalid && shaf_rready) modulo 16, covering 16 words per block in both modes.
REQ-014 Bit counter tx_bits (128b) SHALL add W on every accepted message or pad word.
REQ-015 Both counters SHALL clear on hash_start.
REQ-016 hash_process_flag SHALL set on hash_process and clear on hash_done or hash_start; hash_process SHALL win if it coincides with either.
REQ-017 FSM states SHALL be Idle, Receive, Pad80, Pad00, LenHi, LenLo.
REQ-018 Idle SHALL go to Receive on sha_en && hash_start.
REQ-019 Receive: if fifo_rvalid and the active mask is not all-ones, the FSM SHALL go to Pad80 without popping the FIFO.
REQ-020 Receive: else if the flag is clear, the FIFO SHALL pass through (shaf_rvalid=fifo_rvalid, fifo_rready=shaf_rready).
REQ-021 Receive: else if tx_bits==message_length, the FSM SHALL go to Pad80; otherwise the FIFO SHALL keep passing through.
REQ-022 Pad80: shaf_rvalid SHALL be 1.
REQ-023 Pad80 data: with b = message_length[4:3] (SHA-256) or message_length[5:3] (SHA-512), the top b bytes SHALL carry fifo_rdata, followed by byte 0x80, then zeros.
REQ-024 Pad80 FIFO pop: fifo_rready SHALL equal shaf_rready && (b!=0).
REQ-025 Pad80 on accept: the FSM SHALL go to LenHi if widx==13, else to Pad00.
REQ-026 Pad00: the word SHALL be 0; on accept the FSM SHALL go to LenHi if widx==13, else stay in Pad00, with widx wrapping 15->0.
REQ-027 LenHi SHALL output the upper half of the length field: SHA-256 message_length[63:32]; SHA-512 message_length[127:64].
REQ-028 LenLo SHALL output the lower half: SHA-256 message_length[31:0]; SHA-512 message_length[63:0].
REQ-029 Each of LenHi and LenLo SHALL advance on accept, and LenLo SHALL go to Idle.
REQ-030 Output data SHALL be held stable while shaf_rvalid && !shaf_rready.
REQ-031 hash_start in any non-Idle state SHALL restart: go to Receive, clear the counters, and re-latch mode_q.
REQ-032 sha_en low in any state SHALL force Idle on the next cycle, with no output valid.
REQ-033 msg_feed_complete SHALL equal hash_process_flag && state==Idle.

Reset
REQ-034 On rst_ni low at a clock edge, the FSM SHALL enter Idle, and the counters, mode_q and the flag SHALL clear.
REQ-035 During reset, shaf_rvalid, fifo_rready and msg_feed_complete SHALL be 0 and shaf_rdata SHALL be 0.
REQ-036 Reset asserted mid-hash SHALL abandon the hash with no further output.

Structure
REQ-037 Package sha2_pkg SHALL hold sha2_mode_e, sha_word_t (DataW), the pad state enum, and the constants BlockWords=16 and LenHiIdx=14.
REQ-038 One combinational sub-module, sha2_pad80_gen, SHALL produce the Pad80 word from data, mode and b.

Verification
REQ-039 SHA-256, len=24, word 0x61626300 with mask 1110 -> 16 words: 0x61626380, 13x0, 0x0, 0x18; msg_feed_complete=1 after.
REQ-040 SHA-512, len=24, word 0x6162630000000000 with mask 0xE0 -> 0x6162638000000000, 13x0, 0x0, 0x18.
REQ-041 SHA-256, len=448, 14 full words -> Pad80 at widx 14, then 15 zero words, then LenHi 0 and LenLo 0x1C0: 32 words total.
REQ-042 SHA-512, len=832, 13 full words -> 0x8000000000000000 at widx 13, then directly LenHi 0 and LenLo 0x340: 16 words.
REQ-043 shaf_rready low for 5 cycles during LenLo -> shaf_rvalid=1 and data held constant, with no counter change.
REQ-044 hash_start during Pad00 -> Receive next cycle with tx_bits=0; sha_en dropped in Pad80 -> Idle, no FIFO pop.
